ahb2apb_bridge: RTL and testbench
=================================

// Module: ahb2apb_bridge
// PURPOSE
//  AHB-Lite slave that converts each accepted AHB transfer into one APB4 SETUP/ACCESS transfer.
//  Sits directly downstream of the AHB master port: it consumes haddr/hwdata/htrans/hsel/hready
//  and returns hreadyout/hrdata. On the other side it drives the APB peripheral bus.
//  Handles one transfer at a time. A new address phase is accepted in the cycle the previous
//  transfer completes.
// PARAMETERS
//  AHB_AW  32  AHB address width
//  AHB_DW  32  AHB/APB data width; only 32 is supported
//  APB_AW  32  APB address width; paddr = haddr[APB_AW-1:0] (APB_AW <= AHB_AW)
// PORTS
//  clk        in   1        bus clock, rising edge
//  reset_n    in   1        asynchronous, active-low reset
//  hsel       in   1        slave select
//  haddr      in   AHB_AW   address phase address
//  htrans     in   2        IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//  hwrite     in   1        1 = write
//  hsize      in   3        transfer size
//  hburst     in   3        burst type; unused, each beat is handled as a single transfer
//  hwdata     in   AHB_DW   write data, data phase
//  hready     in   1        bus-level ready (previous data phase ends)
//  hreadyout  out  1        slave ready
//  hrdata     out  AHB_DW   read data
//  hresp      out  1        error response; present only with AHB2APB_HRESP_EN
//  paddr      out  APB_AW   APB address
//  psel       out  1        APB select
//  penable    out  1        APB enable
//  pwrite     out  1        APB direction
//  pwdata     out  AHB_DW   APB write data
//  pstrb      out  4        APB4 byte strobes
//  prdata     in   AHB_DW   APB read data
//  pready     in   1        APB ready
//  pslverr    in   1        APB error
// BEHAVIOUR
//  Reset values: hreadyout=1, hrdata=0, hresp=0, paddr=0, psel=0, penable=0, pwrite=0,
//   pwdata=0, pstrb=0, FSM=IDLE. Reset acts immediately and aborts any APB transfer.
//  Accept condition: hsel & hready & htrans[1]. On accept, register haddr, hwrite and hsize.
//  IDLE/BUSY transfers, or hsel=0: ignored; OKAY with zero wait states.
//  FSM states:
//   IDLE   : hreadyout=1. Accept -> SETUP.
//   SETUP  : psel=1, penable=0, hreadyout=0. pwdata is registered from hwdata on entry into ACCESS;
//            APB SETUP sees pwdata only as valid from ACCESS. -> ACCESS.
//   ACCESS : psel=1, penable=1. Stay while pready=0.
//            pready=1 & (pslverr=0 or macro off) -> DONE, and hrdata<=prdata on reads.
//            pready=1 & pslverr=1 with macro on -> ERR1.
//   DONE   : psel=0, hreadyout=1. Accept -> SETUP, otherwise -> IDLE.
//   ERR1   : hresp=1, hreadyout=0 -> ERR2.
//   ERR2   : hresp=1, hreadyout=1. Accept -> SETUP, otherwise -> IDLE.
//  Minimum latency: 3 data-phase cycles (SETUP, ACCESS, DONE). Each extra pready=0 cycle adds one.
//  paddr, pwrite and pstrb are held stable from SETUP through the end of ACCESS.
//  pstrb on writes (ahb2apb_strb):
//   hsize=0: 4'b0001 << haddr[1:0]
//   hsize=1: 4'b0011 << {haddr[1],1'b0}
//   hsize>=2: 4'hF
//  pstrb on reads: 4'h0.
//  hrdata holds its last value until the next completed read.
// CONFIGURATION
//  AHB2APB_HRESP_EN defined:
//   hresp port exists; pslverr produces the 2-cycle AHB ERROR response (ERR1, ERR2).
//  AHB2APB_HRESP_EN undefined:
//   hresp port is absent; pslverr is ignored; ERR1/ERR2 are unreachable.
// STRUCTURE
//  ahb2apb_pkg holds:
//   - htrans_e and hsize_e enums
//   - bridge_state_e (IDLE, SETUP, ACCESS, DONE, ERR1, ERR2)
//   - constants HTRANS_NONSEQ and HTRANS_SEQ
//  Sub-module ahb2apb_strb: combinational map {hwrite, hsize, haddr[1:0]} -> pstrb.
// TESTING
//  1. Write 0xDEADBEEF to 0x40, hsize=2, pready=1 -> paddr=0x40, pstrb=F, pwdata=0xDEADBEEF in ACCESS;
//     hreadyout low for exactly 2 cycles.
//  2. Read 0x44 with pready low for 3 ACCESS cycles, prdata=0x1234 -> hreadyout low for 5 cycles;
//     hrdata=0x1234 in DONE.
//  3. Back-to-back NONSEQ write 0x10 then read 0x14, second address presented in DONE
//     -> second SETUP the next cycle, no IDLE in between.
//  4. Byte write to 0x13 (hsize=0) -> pstrb=4'b1000. Halfword write to 0x12 -> pstrb=4'b1100.
//  5. With the macro on, pslverr=1 at completion -> hresp=1 for 2 cycles, hreadyout 0 then 1.
//     With the macro off -> OKAY.
//  6. reset_n low during ACCESS -> psel, penable=0 and hreadyout=1 immediately;
//     after release, an IDLE htrans produces no APB activity.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB4 bridge.
package ahb2apb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SizeByte  = 3'd0,
    SizeHalf  = 3'd1,
    SizeWord  = 3'd2,
    SizeDword = 3'd3,
    Size4Word = 3'd4,
    Size8Word = 3'd5,
    Size512   = 3'd6,
    Size1024  = 3'd7
  } hsize_e;

  typedef enum logic [2:0] {
    BrIdle   = 3'd0,
    BrSetup  = 3'd1,
    BrAccess = 3'd2,
    BrDone   = 3'd3,
    BrErr1   = 3'd4,
    BrErr2   = 3'd5
  } bridge_state_e;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/ahb2apb_if.sv
// AHB-Lite slave port plus APB4 master port of the bridge, bundled as one interface.
// hresp exists only when AHB2APB_HRESP_EN is defined.
interface ahb2apb_if #(
  parameter int unsigned AHB_AW = 32,
  parameter int unsigned AHB_DW = 32,
  parameter int unsigned APB_AW = 32
) ();
  logic              hsel;
  logic [AHB_AW-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [AHB_DW-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic [AHB_DW-1:0] hrdata;
`ifdef AHB2APB_HRESP_EN
  logic              hresp;
`endif
  logic [APB_AW-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AHB_DW-1:0] pwdata;
  logic [3:0]        pstrb;
  logic [AHB_DW-1:0] prdata;
  logic              pready;
  logic              pslverr;

`ifdef AHB2APB_HRESP_EN
  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready, prdata, pready, pslverr,
    output hreadyout, hrdata, hresp, paddr, psel, penable, pwrite, pwdata, pstrb
  );
  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready, prdata, pready, pslverr,
    input  hreadyout, hrdata, hresp, paddr, psel, penable, pwrite, pwdata, pstrb
  );
`else
  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready, prdata, pready, pslverr,
    output hreadyout, hrdata, paddr, psel, penable, pwrite, pwdata, pstrb
  );
  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready, prdata, pready, pslverr,
    input  hreadyout, hrdata, paddr, psel, penable, pwrite, pwdata, pstrb
  );
`endif

endinterface

// File: rtl/ahb2apb_strb.sv
// APB4 byte-strobe decode from the registered transfer attributes; reads never strobe.
module ahb2apb_strb
  import ahb2apb_pkg::*;
(
  input  logic       i_hwrite,
  input  logic [2:0] i_hsize,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_pstrb
);
  hsize_e w_size;

  assign w_size = hsize_e'(i_hsize);

  always_comb begin
    o_pstrb = 4'h0;
    if (i_hwrite) begin
      case (w_size)
        SizeByte: o_pstrb = 4'b0001 << i_addr_lo;
        SizeHalf: o_pstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
        default:  o_pstrb = 4'hF;
      endcase
    end
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB4 bridge: one APB SETUP/ACCESS transfer per accepted AHB transfer.
// Define AHB2APB_HRESP_EN to add hresp and map pslverr onto a two-cycle AHB ERROR response.
module ahb2apb_bridge
  import ahb2apb_pkg::*;
#(
  parameter int unsigned AHB_AW = 32,
  parameter int unsigned AHB_DW = 32,
  parameter int unsigned APB_AW = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  ahb2apb_if.slave bus
);
  localparam logic [2:0] S_IDLE   = BrIdle;
  localparam logic [2:0] S_SETUP  = BrSetup;
  localparam logic [2:0] S_ACCESS = BrAccess;
  localparam logic [2:0] S_DONE   = BrDone;
  localparam logic [2:0] S_ERR1   = BrErr1;
  localparam logic [2:0] S_ERR2   = BrErr2;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [APB_AW-1:0] r_paddr;
  logic              r_pwrite;
  logic [2:0]        r_hsize;
  logic [AHB_DW-1:0] r_pwdata;
  logic [AHB_DW-1:0] r_hrdata;
  logic [AHB_AW-1:0] w_haddr;
  logic              w_ready_state;
  logic              w_trans_valid;
  logic              w_accept;
  logic              w_complete;
  logic              w_err;
  logic              w_unused;

  assign w_haddr       = bus.haddr;
  assign w_ready_state = (r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR2);
  assign w_trans_valid = (bus.htrans == HTRANS_NONSEQ) | (bus.htrans == HTRANS_SEQ);
  // Only sample a new address phase while this slave is signalling ready.
  assign w_accept      = bus.hsel & bus.hready & w_trans_valid & w_ready_state;
  assign w_complete    = (r_state == S_ACCESS) & bus.pready;

`ifdef AHB2APB_HRESP_EN
  assign w_err     = bus.pslverr;
  assign bus.hresp = (r_state == S_ERR1) | (r_state == S_ERR2);
  assign w_unused  = ^{bus.hburst, w_haddr};
`else
  assign w_err     = 1'b0;
  assign w_unused  = ^{bus.hburst, w_haddr, bus.pslverr};
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR2: w_state_nxt = w_accept ? S_SETUP : S_IDLE;
      S_SETUP:                w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (bus.pready) w_state_nxt = w_err ? S_ERR1 : S_DONE;
      end
      S_ERR1:                 w_state_nxt = S_ERR2;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_hsize  <= 3'd0;
      r_pwdata <= '0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_paddr  <= w_haddr[APB_AW-1:0];
        r_pwrite <= bus.hwrite;
        r_hsize  <= bus.hsize;
      end
      // hwdata belongs to the data phase, which coincides with SETUP.
      if ((r_state == S_SETUP) && r_pwrite) r_pwdata <= bus.hwdata;
      if (w_complete && !w_err && !r_pwrite) r_hrdata <= bus.prdata;
    end
  end

  ahb2apb_strb u_strb (
    .i_hwrite  (r_pwrite),
    .i_hsize   (r_hsize),
    .i_addr_lo (r_paddr[1:0]),
    .o_pstrb   (bus.pstrb)
  );

  assign bus.hreadyout = w_ready_state;
  assign bus.hrdata    = r_hrdata;
  assign bus.paddr     = r_paddr;
  assign bus.psel      = (r_state == S_SETUP) | (r_state == S_ACCESS);
  assign bus.penable   = (r_state == S_ACCESS);
  assign bus.pwrite    = r_pwrite;
  assign bus.pwdata    = r_pwdata;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Randomized self-checking bench for ahb2apb_bridge against a transaction-level reference model.
// Builds with or without AHB2APB_HRESP_EN.
module tb_ahb2apb_bridge;
  import ahb2apb_pkg::*;

`ifdef AHB2APB_HRESP_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_hrdata;

  ahb2apb_if #(.AHB_AW(32), .AHB_DW(32), .APB_AW(32)) bus ();

  ahb2apb_bridge #(.AHB_AW(32), .AHB_DW(32), .APB_AW(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.hready = bus.hreadyout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Byte lanes covered by a naturally aligned access of the given size.
  function automatic logic [3:0] ref_strb(input bit wr, input logic [31:0] addr,
                                          input logic [2:0] size);
    logic [3:0] s;
    int         nb;
    int         base;
    s = 4'h0;
    if (wr) begin
      nb   = (size >= 3'd2) ? 4 : ((size == 3'd1) ? 2 : 1);
      base = (int'(addr[1:0]) / nb) * nb;
      for (int b = 0; b < 4; b++) s[b] = (b >= base) && (b < base + nb);
    end
    return s;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(2))
        0:       begin bus.hsel = 1'b0; bus.htrans = 2'($urandom); end
        1:       begin bus.hsel = 1'b1; bus.htrans = TransIdle; end
        default: begin bus.hsel = 1'b1; bus.htrans = TransBusy; end
      endcase
      bus.haddr   = $urandom;
      bus.hwrite  = 1'($urandom);
      bus.pready  = 1'($urandom);
      bus.pslverr = 1'($urandom);
      bus.prdata  = $urandom;
      @(posedge clk);
      @(negedge clk);
      check_eq("idle_psel", 32'(bus.psel), 32'd0);
      check_eq("idle_hreadyout", 32'(bus.hreadyout), 32'd1);
      check_eq("idle_hrdata", bus.hrdata, model_hrdata);
`ifdef AHB2APB_HRESP_EN
      check_eq("idle_hresp", 32'(bus.hresp), 32'd0);
`endif
    end
  endtask

  // Called at a negedge while the bridge is ready; returns at the negedge of the ready cycle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                      input bit slverr);
    int         lows;
    int         w;
    bit         ended;
    bit         exp_err;
    logic [3:0] exp_strb;
    lows     = 0;
    w        = 0;
    ended    = 1'b0;
    exp_err  = ErrEn && slverr;
    exp_strb = ref_strb(wr, addr, size);

    bus.hsel   = 1'b1;
    bus.htrans = $urandom_range(1) ? HTRANS_SEQ : HTRANS_NONSEQ;
    bus.haddr  = addr;
    bus.hwrite = wr;
    bus.hsize  = size;
    bus.hburst = 3'($urandom);
    bus.hwdata = $urandom;
    @(posedge clk);
    #1;
    bus.hsel   = 1'($urandom);
    bus.htrans = TransIdle;
    bus.haddr  = $urandom;
    bus.hwrite = 1'($urandom);
    bus.hsize  = 3'($urandom);
    bus.hwdata = wdata;

    for (int c = 0; c < 40 && !ended; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_eq("setup_psel", 32'(bus.psel), 32'd1);
        check_eq("setup_penable", 32'(bus.penable), 32'd0);
      end
      if (bus.hreadyout) begin
        ended = 1'b1;
      end else begin
        lows++;
        if (bus.psel) begin
          check_eq("paddr", bus.paddr, addr);
          check_eq("pwrite", 32'(bus.pwrite), 32'(wr));
          check_eq("pstrb", 32'(bus.pstrb), 32'(exp_strb));
          if (bus.penable) begin
            if (wr) check_eq("pwdata", bus.pwdata, wdata);
            if (w < waits) begin
              bus.pready  = 1'b0;
              bus.pslverr = 1'($urandom);
              bus.prdata  = $urandom;
              w++;
            end else begin
              bus.pready  = 1'b1;
              bus.pslverr = slverr;
              bus.prdata  = rdata;
            end
          end else begin
            bus.pready  = 1'($urandom);
            bus.pslverr = 1'($urandom);
            bus.prdata  = $urandom;
          end
        end else begin
`ifdef AHB2APB_HRESP_EN
          check_eq("err1_hresp", 32'(bus.hresp), 32'd1);
`endif
          bus.pready = 1'($urandom);
        end
      end
    end

    check_eq("timeout", 32'(ended), 32'd1);
    check_eq("low_cycles", 32'(lows), 32'(2 + waits + int'(exp_err)));
    check_eq("end_psel", 32'(bus.psel), 32'd0);
    check_eq("end_penable", 32'(bus.penable), 32'd0);
    if (!wr && !exp_err) model_hrdata = rdata;
    check_eq("hrdata", bus.hrdata, model_hrdata);
`ifdef AHB2APB_HRESP_EN
    check_eq("end_hresp", 32'(bus.hresp), 32'(exp_err));
`endif
  endtask

  task automatic reset_in_access();
    bus.hsel   = 1'b1;
    bus.htrans = HTRANS_NONSEQ;
    bus.haddr  = 32'h80;
    bus.hwrite = 1'b1;
    bus.hsize  = 3'd2;
    @(posedge clk);
    #1;
    bus.hsel   = 1'b0;
    bus.htrans = TransIdle;
    bus.hwdata = 32'h1357_9BDF;
    bus.pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pre_penable", 32'(bus.penable), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_hrdata = 32'h0;
    check_eq("rst_psel", 32'(bus.psel), 32'd0);
    check_eq("rst_penable", 32'(bus.penable), 32'd0);
    check_eq("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
    check_eq("rst_paddr", bus.paddr, 32'h0);
    check_eq("rst_pwdata", bus.pwdata, 32'h0);
    check_eq("rst_pstrb", 32'(bus.pstrb), 32'h0);
    check_eq("rst_hrdata", bus.hrdata, 32'h0);
    @(negedge clk);
    reset_n    = 1'b1;
    bus.hsel   = 1'b1;
    bus.htrans = TransIdle;
    bus.pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_psel", 32'(bus.psel), 32'd0);
      check_eq("post_rst_hreadyout", 32'(bus.hreadyout), 32'd1);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    model_hrdata = 32'h0;
    bus.hsel     = 1'b0;
    bus.haddr    = '0;
    bus.htrans   = TransIdle;
    bus.hwrite   = 1'b0;
    bus.hsize    = 3'd0;
    bus.hburst   = 3'd0;
    bus.hwdata   = '0;
    bus.prdata   = '0;
    bus.pready   = 1'b1;
    bus.pslverr  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_hreadyout", 32'(bus.hreadyout), 32'd1);
    check_eq("reset_hrdata", bus.hrdata, 32'h0);
    check_eq("reset_paddr", bus.paddr, 32'h0);
    check_eq("reset_psel", 32'(bus.psel), 32'd0);
    check_eq("reset_penable", 32'(bus.penable), 32'd0);
    check_eq("reset_pwrite", 32'(bus.pwrite), 32'd0);
    check_eq("reset_pwdata", bus.pwdata, 32'h0);
    check_eq("reset_pstrb", 32'(bus.pstrb), 32'h0);
`ifdef AHB2APB_HRESP_EN
    check_eq("reset_hresp", 32'(bus.hresp), 32'd0);
`endif
    reset_n = 1'b1;
    idle_cycles(2);

    xfer(1'b1, 32'h40, 3'd2, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    idle_cycles(1);
    xfer(1'b0, 32'h44, 3'd2, 32'h0, 32'h0000_1234, 3, 1'b0);
    idle_cycles(1);
    xfer(1'b1, 32'h10, 3'd2, 32'hA5A5_0001, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h14, 3'd2, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
    xfer(1'b1, 32'h13, 3'd0, 32'h7700_0000, 32'h0, 0, 1'b0);
    xfer(1'b1, 32'h12, 3'd1, 32'h6655_0000, 32'h0, 2, 1'b0);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, 32'h0000_5555, 0, 1'b1);
    xfer(1'b1, 32'h24, 3'd2, 32'h0BAD_0BAD, 32'h0, 1, 1'b1);
    idle_cycles(1);
    reset_in_access();

    for (int i = 0; i < 60; i++) begin
      xfer(1'($urandom), $urandom, 3'($urandom_range(3)), $urandom, $urandom,
           int'($urandom_range(3)), ($urandom_range(3) == 0));
      if ($urandom_range(1) == 1) idle_cycles(int'($urandom_range(1, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
